// File: rtl/fp32_square_seq.sv
// Multi-cycle FP32 squarer C = A*A using a radix-2^RADIX_BITS shift-add mantissa engine.
// Truncating, denormal-flushing packing identical to the FP32 multiplier; valid/ready on both sides.
module fp32_square_seq #(
   parameter int RADIX_BITS = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] C,
   output logic        ovf,
   output logic        unf
);

   localparam int         MUL_CYCLES = 24 / RADIX_BITS;
   localparam logic [4:0] LAST_CNT   = 5'(MUL_CYCLES - 1);
   localparam logic [31:0] QNAN      = 32'h7FC0_0000;
   localparam logic [31:0] PINF      = 32'h7F80_0000;

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [7:0]  exp_q, exp_d;
   logic [47:0] mcand_q, mcand_d;
   logic [23:0] mplier_q, mplier_d;
   logic [47:0] acc_q, acc_d;
   logic [31:0] c_q, c_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;

   logic [RADIX_BITS-1:0] digit;
   logic [47:0]           pp;
   logic signed [9:0]     x_exp;
   logic [22:0]           mant;
   logic                  sign_unused;

   // The result is always non-negative, so the operand sign is never consumed.
   assign sign_unused = A[31];

   always_comb begin
      digit = mplier_q[RADIX_BITS-1:0];
      pp    = mcand_q * {{(48 - RADIX_BITS){1'b0}}, digit};
      x_exp = $signed({1'b0, exp_q, 1'b0}) - 10'sd127 + $signed({9'd0, acc_q[47]});
      mant  = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      exp_d    = exp_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      c_d      = c_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               exp_d = A[30:23];
               if (A[30:23] == 8'd0) begin
                  c_d     = 32'h0;
                  ovf_d   = 1'b0;
                  unf_d   = 1'b0;
                  state_d = DONE;
               end else if (A[30:23] == 8'hFF) begin
                  c_d     = (A[22:0] != 23'd0) ? QNAN : PINF;
                  ovf_d   = 1'b0;
                  unf_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  mcand_d  = {24'd0, 1'b1, A[22:0]};
                  mplier_d = {1'b1, A[22:0]};
                  acc_d    = 48'd0;
                  cnt_d    = 5'd0;
                  state_d  = MUL;
               end
            end
         end
         MUL: begin
            // Multiplier digits are retired LSB first; the multiplicand walks up to match.
            acc_d    = acc_q + pp;
            mcand_d  = mcand_q << RADIX_BITS;
            mplier_d = mplier_q >> RADIX_BITS;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) state_d = NORM;
         end
         NORM: begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            if (x_exp >= 10'sd255) begin
               c_d   = PINF;
               ovf_d = 1'b1;
            end else if (x_exp <= 10'sd0) begin
               c_d   = 32'h0;
               unf_d = 1'b1;
            end else begin
               c_d = {1'b0, x_exp[7:0], mant};
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         acc_q   <= 48'd0;
         c_q     <= 32'h0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Operand working registers are always reloaded at acceptance, so they carry no reset.
   always_ff @(posedge clk) begin
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign C         = c_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;

endmodule

// File: tb/tb_fp32_square_seq.sv
// Bench for fp32_square_seq: directed and random operands against a full-product reference model.
module tb_fp32_square_seq;

   localparam int RADIX_BITS = 1;
   localparam int NORM_LAT   = 24 / RADIX_BITS + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] C;
   logic        ovf;
   logic        unf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp32_square_seq #(.RADIX_BITS(RADIX_BITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .C         (C),
      .ovf       (ovf),
      .unf       (unf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Square computed as one full 48-bit product, then packed by the truncating rules.
   function automatic void model(input logic [31:0] a, output logic [31:0] c,
                                 output logic o, output logic u, output int lat);
      logic [7:0]  e;
      logic [47:0] m;
      logic [47:0] p;
      int          x;
      logic [22:0] mt;
      e = a[30:23];
      o = 1'b0;
      u = 1'b0;
      lat = 1;
      if (e == 8'd0) begin
         c = 32'h0;
      end else if (e == 8'hFF) begin
         c = (a[22:0] != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
      end else begin
         m   = {24'd0, 1'b1, a[22:0]};
         p   = m * m;
         x   = 2 * int'(e) - 127 + int'(p[47]);
         mt  = p[47] ? p[46:24] : p[45:23];
         lat = NORM_LAT;
         if (x >= 255) begin
            c = 32'h7F800000;
            o = 1'b1;
         end else if (x <= 0) begin
            c = 32'h0;
            u = 1'b1;
         end else begin
            c = {1'b0, x[7:0], mt};
         end
      end
   endfunction

   task automatic run_op(input logic [31:0] a);
      logic [31:0] ec;
      logic        eo;
      logic        eu;
      int          el;
      int          n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      in_valid = 1'b1;
      A        = a;
      @(posedge clk); #1;
      in_valid = 1'b0;
      A        = $urandom;
      n = 1;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1; n++;
      end
      model(a, ec, eo, eu, el);
      check($sformatf("C(%h)", a), C, ec);
      check($sformatf("ovf(%h)", a), {31'd0, ovf}, {31'd0, eo});
      check($sformatf("unf(%h)", a), {31'd0, unf}, {31'd0, eu});
      check($sformatf("latency(%h)", a), n, el);
      @(posedge clk); #1;
      check($sformatf("valid_drop(%h)", a), {31'd0, out_valid}, 32'd0);
      check($sformatf("ready_back(%h)", a), {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] r;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_C", C, 32'h0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_unf", {31'd0, unf}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;

      run_op(32'h40400000);
      check("three_sq", C, 32'h41100000);
      run_op(32'hC0000000);
      check("neg_two_sq", C, 32'h40800000);
      run_op(32'h3FC00000);
      check("one_half_sq", C, 32'h40100000);
      run_op(32'h60AD78EC);
      run_op(32'h1E3CE508);
      run_op(32'h7FC00001);
      run_op(32'hFF800000);
      run_op(32'h80000000);
      run_op(32'h00000001);
      run_op(32'h7F7FFFFF);

      for (int i = 0; i < 24; i++) begin
         r = $urandom;
         if (i % 2 == 0) r[30:23] = 8'(60 + $urandom_range(0, 135));
         run_op(r);
      end

      // Backpressure: result must hold while the consumer stalls, and new requests are ignored.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      A         = 32'h40400000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 0; n < 200 && !out_valid; n++) begin
         @(posedge clk); #1;
      end
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         A        = 32'h40000000;
         @(posedge clk); #1;
         check("bp_C_stable", C, 32'h41100000);
         check("bp_valid_held", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
      check("bp_ready_back", {31'd0, in_ready}, 32'd1);
      check("bp_C_kept", C, 32'h41100000);

      // Reset in the middle of a multiply discards the operation.
      in_valid = 1'b1;
      A        = 32'h40400000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_C", C, 32'h0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      run_op(32'h40400000);
      check("post_rst_three_sq", C, 32'h41100000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
